// File: rtl/keccak_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | keccak_seq_pkg : shared types, defaults and command priority     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package keccak_seq_pkg;

   localparam int c_rate_lanes_def = 17;
   localparam int c_rounds_def     = 24;
   localparam int c_ans_max_def    = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ABSORB  = 3'd1,
      ST_PERMUTE = 3'd2,
      ST_SQUEEZE = 3'd3,
      ST_FIN     = 3'd4
   } seq_state_t;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_CLEAR = 3'd1,
      CMD_START = 3'd2,
      CMD_ANS   = 3'd3,
      CMD_LOAD  = 3'd4,
      CMD_ROUND = 3'd5
   } seq_cmd_t;

   // Only the highest-priority strobe survives; the rest are silently dropped.
   function automatic seq_cmd_t encode_cmd(
      input logic step_en,
      input logic clear,
      input logic start,
      input logic load,
      input logic round,
      input logic ans
   );
      if (!step_en)   return CMD_NONE;
      else if (clear) return CMD_CLEAR;
      else if (start) return CMD_START;
      else if (ans)   return CMD_ANS;
      else if (load)  return CMD_LOAD;
      else if (round) return CMD_ROUND;
      else            return CMD_NONE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_limit_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_limit_counter : 5-bit up counter with clear and last flag    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seq_limit_counter #(
   parameter int LIMIT = 17
) (
   input  logic       clk,
   input  logic       ovr_rst1,
   input  logic       clr,
   input  logic       inc,
   output logic [4:0] count,
   output logic       at_limit
);

   localparam logic [4:0] c_last = 5'(LIMIT - 1);

   logic [4:0] r_count;

   always_ff @(posedge clk or posedge ovr_rst1) begin
      if (ovr_rst1)
         r_count <= 5'd0;
      else if (clr)
         r_count <= 5'd0;
      else if (inc)
         r_count <= r_count + 5'd1;
   end

   assign count    = r_count;
   assign at_limit = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/keccak_seq_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | keccak_seq_responder : hash strobes -> absorb/permute/squeeze    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module keccak_seq_responder
   import keccak_seq_pkg::*;
#(
   parameter int RATE_LANES = c_rate_lanes_def,
   parameter int ROUNDS     = c_rounds_def,
   parameter int ANS_MAX    = c_ans_max_def
) (
   input  logic       clk,
   input  logic       ovr_rst1,
   input  logic       step_en,
   input  logic       cmd_clear,
   input  logic       cmd_start,
   input  logic       cmd_load,
   input  logic       cmd_round,
   input  logic       cmd_ans,
   output logic       state_clr,
   output logic       lane_we,
   output logic [4:0] lane_addr,
   output logic       round_en,
   output logic [4:0] round_idx,
   output logic       ans_valid,
   output logic [1:0] ans_cnt,
   output logic       busy,
   output logic       fin,
   output logic       proto_err
);

   localparam logic [1:0] c_ans_max = 2'(ANS_MAX);

   seq_state_t r_state;
   seq_state_t w_state_nxt;
   seq_cmd_t   w_cmd;

   logic [4:0] w_lane_cnt;
   logic [4:0] w_rnd_cnt;
   logic       w_lane_last;
   logic       w_rnd_last;
   logic       w_lane_clr;
   logic       w_lane_inc;
   logic       w_rnd_clr;
   logic       w_rnd_inc;

   logic [1:0] r_ans_cnt;
   logic [1:0] w_ans_nxt;
   logic [1:0] w_ans_inc;
   logic       r_proto_err;
   logic       w_err_nxt;
   logic       w_clr_pulse;
   logic       w_we_pulse;
   logic       w_round_pulse;
   logic       w_ans_pulse;

   assign w_cmd     = encode_cmd(step_en, cmd_clear, cmd_start, cmd_load, cmd_round, cmd_ans);
   assign w_ans_inc = r_ans_cnt + 2'd1;

   seq_limit_counter #(.LIMIT(RATE_LANES)) u_lane_cnt (
      .clk      (clk),
      .ovr_rst1 (ovr_rst1),
      .clr      (w_lane_clr),
      .inc      (w_lane_inc),
      .count    (w_lane_cnt),
      .at_limit (w_lane_last)
   );

   seq_limit_counter #(.LIMIT(ROUNDS)) u_rnd_cnt (
      .clk      (clk),
      .ovr_rst1 (ovr_rst1),
      .clr      (w_rnd_clr),
      .inc      (w_rnd_inc),
      .count    (w_rnd_cnt),
      .at_limit (w_rnd_last)
   );

   always_ff @(posedge clk or posedge ovr_rst1) begin
      if (ovr_rst1)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_lane_clr    = 1'b0;
      w_lane_inc    = 1'b0;
      w_rnd_clr     = 1'b0;
      w_rnd_inc     = 1'b0;
      w_ans_nxt     = r_ans_cnt;
      w_err_nxt     = r_proto_err;
      w_clr_pulse   = 1'b0;
      w_we_pulse    = 1'b0;
      w_round_pulse = 1'b0;
      w_ans_pulse   = 1'b0;

      if (w_cmd == CMD_CLEAR) begin
         w_state_nxt = ST_IDLE;
         w_lane_clr  = 1'b1;
         w_rnd_clr   = 1'b1;
         w_ans_nxt   = 2'd0;
         w_err_nxt   = 1'b0;
         w_clr_pulse = 1'b1;
      end else if (w_cmd != CMD_NONE) begin
         // Any command not legal in the current state only raises the flag.
         case (r_state)
            ST_IDLE: begin
               if (w_cmd == CMD_START) begin
                  w_state_nxt = ST_ABSORB;
                  w_lane_clr  = 1'b1;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
            ST_ABSORB: begin
               if (w_cmd == CMD_START) begin
                  w_lane_clr = 1'b1;
               end else if (w_cmd == CMD_LOAD) begin
                  w_we_pulse = 1'b1;
                  if (w_lane_last) begin
                     w_state_nxt = ST_PERMUTE;
                     w_rnd_clr   = 1'b1;
                  end else begin
                     w_lane_inc = 1'b1;
                  end
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
            ST_PERMUTE: begin
               if (w_cmd == CMD_ROUND) begin
                  w_round_pulse = 1'b1;
                  if (w_rnd_last)
                     w_state_nxt = ST_SQUEEZE;
                  else
                     w_rnd_inc = 1'b1;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
            ST_SQUEEZE: begin
               if (w_cmd == CMD_ANS) begin
                  w_ans_pulse = 1'b1;
                  w_ans_nxt   = w_ans_inc;
                  if (w_ans_inc == c_ans_max) begin
                     w_state_nxt = ST_FIN;
                  end else begin
                     w_state_nxt = ST_ABSORB;
                     w_lane_clr  = 1'b1;
                  end
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
            ST_FIN: begin
               w_err_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Index outputs read back as zero outside their strobe cycle.
   always_ff @(posedge clk or posedge ovr_rst1) begin
      if (ovr_rst1) begin
         state_clr   <= 1'b0;
         lane_we     <= 1'b0;
         lane_addr   <= 5'd0;
         round_en    <= 1'b0;
         round_idx   <= 5'd0;
         ans_valid   <= 1'b0;
         r_ans_cnt   <= 2'd0;
         busy        <= 1'b0;
         fin         <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         state_clr   <= w_clr_pulse;
         lane_we     <= w_we_pulse;
         lane_addr   <= w_we_pulse ? w_lane_cnt : 5'd0;
         round_en    <= w_round_pulse;
         round_idx   <= w_round_pulse ? w_rnd_cnt : 5'd0;
         ans_valid   <= w_ans_pulse;
         r_ans_cnt   <= w_ans_nxt;
         busy        <= (w_state_nxt == ST_ABSORB) || (w_state_nxt == ST_PERMUTE)
                        || (w_state_nxt == ST_SQUEEZE);
         fin         <= (w_state_nxt == ST_FIN);
         r_proto_err <= w_err_nxt;
      end
   end

   assign ans_cnt   = r_ans_cnt;
   assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_keccak_seq_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_keccak_seq_responder : directed vectors for the hash sequencer|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_keccak_seq_responder;

   logic clk = 1'b0;
   logic ovr_rst1 = 1'b1;
   logic step_en = 1'b0;
   logic cmd_clear = 1'b0;
   logic cmd_start = 1'b0;
   logic cmd_load = 1'b0;
   logic cmd_round = 1'b0;
   logic cmd_ans = 1'b0;

   logic       state_clr, lane_we, round_en, ans_valid, busy, fin, proto_err;
   logic [4:0] lane_addr, round_idx;
   logic [1:0] ans_cnt;
   logic [18:0] w_outs;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   keccak_seq_responder dut (
      .clk       (clk),
      .ovr_rst1  (ovr_rst1),
      .step_en   (step_en),
      .cmd_clear (cmd_clear),
      .cmd_start (cmd_start),
      .cmd_load  (cmd_load),
      .cmd_round (cmd_round),
      .cmd_ans   (cmd_ans),
      .state_clr (state_clr),
      .lane_we   (lane_we),
      .lane_addr (lane_addr),
      .round_en  (round_en),
      .round_idx (round_idx),
      .ans_valid (ans_valid),
      .ans_cnt   (ans_cnt),
      .busy      (busy),
      .fin       (fin),
      .proto_err (proto_err)
   );

   assign w_outs = {state_clr, lane_we, lane_addr, round_en, round_idx,
                    ans_valid, ans_cnt, busy, fin, proto_err};

   typedef struct {
      string       nm;
      logic        en, c, s, l, r, a;
      logic [18:0] exp;
   } vec_t;

   vec_t tbl[14];

   function automatic logic [18:0] mk(logic sc, logic we, logic [4:0] la, logic re,
                                      logic [4:0] ri, logic av, logic [1:0] ac,
                                      logic b, logic f, logic pe);
      return {sc, we, la, re, ri, av, ac, b, f, pe};
   endfunction

   task automatic chk(input string nm, input logic [18:0] exp);
      n_cmp++;
      if (w_outs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, w_outs, exp);
      end
   endtask

   task automatic step(input logic en, input logic c, input logic s,
                       input logic l, input logic r, input logic a);
      @(negedge clk);
      step_en = en; cmd_clear = c; cmd_start = s;
      cmd_load = l; cmd_round = r; cmd_ans = a;
      @(posedge clk);
      #1;
   endtask

   task automatic absorb(input logic [1:0] ac, input logic pe);
      for (int i = 0; i < 17; i++) begin
         step(1, 0, 0, 1, 0, 0);
         chk("absorb_lane", mk(0, 1, 5'(i), 0, 0, 0, ac, 1, 0, pe));
      end
   endtask

   task automatic permute(input logic [1:0] ac, input logic pe, input int n);
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0, 0, 1, 0);
         chk("permute_round", mk(0, 0, 0, 1, 5'(i), 0, ac, 1, 0, pe));
      end
   endtask

   initial begin
      //             name          en c  s  l  r  a   sc we la   re ri av ac b  f  pe
      tbl[0]  = '{"start",        1, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
      tbl[1]  = '{"load0",        1, 0, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0)};
      tbl[2]  = '{"load1",        1, 0, 0, 1, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0)};
      tbl[3]  = '{"load2",        1, 0, 0, 1, 0, 0, mk(0, 1, 2, 0, 0, 0, 0, 1, 0, 0)};
      tbl[4]  = '{"round_absorb", 1, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1)};
      tbl[5]  = '{"load3_after",  1, 0, 0, 1, 0, 0, mk(0, 1, 3, 0, 0, 0, 0, 1, 0, 1)};
      tbl[6]  = '{"load4",        1, 0, 0, 1, 0, 0, mk(0, 1, 4, 0, 0, 0, 0, 1, 0, 1)};
      tbl[7]  = '{"start_load",   1, 0, 1, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1)};
      tbl[8]  = '{"load_restart", 1, 0, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1)};
      tbl[9]  = '{"ans_over_ld",  1, 0, 0, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1)};
      tbl[10] = '{"clear_start",  1, 1, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[11] = '{"load_idle",    1, 0, 0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
      tbl[12] = '{"clear",        1, 1, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[13] = '{"no_qual",      0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

      #1;
      chk("reset_async", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      ovr_rst1 = 1'b0;
      #1;
      chk("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].en, tbl[i].c, tbl[i].s, tbl[i].l, tbl[i].r, tbl[i].a);
         chk(tbl[i].nm, tbl[i].exp);
      end

      // Unqualified strobes must be invisible.
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 1, 1, 1, 1);
         chk("step_en_low", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end

      // Three complete hash rounds into FIN.
      step(1, 0, 1, 0, 0, 0);
      chk("full_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      absorb(0, 0);
      permute(0, 0, 24);
      step(1, 0, 0, 0, 0, 1);
      chk("ans1", mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
      absorb(1, 0);
      permute(1, 0, 24);
      step(1, 0, 0, 0, 0, 1);
      chk("ans2", mk(0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
      absorb(2, 0);
      permute(2, 0, 24);
      step(1, 0, 0, 0, 0, 1);
      chk("ans3_fin", mk(0, 0, 0, 0, 0, 1, 3, 0, 1, 0));
      step(0, 0, 0, 0, 0, 0);
      chk("fin_hold", mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0));
      step(1, 0, 0, 0, 1, 0);
      chk("fin_round_err", mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 1));
      step(1, 1, 0, 0, 0, 0);
      chk("fin_clear", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Illegal load while squeezing.
      step(1, 0, 1, 0, 0, 0);
      absorb(0, 0);
      permute(0, 0, 24);
      step(1, 0, 0, 1, 0, 0);
      chk("squeeze_load_err", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      step(1, 0, 0, 0, 0, 1);
      chk("squeeze_ans", mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 1));
      step(1, 1, 0, 0, 0, 0);
      chk("clear2", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Start in PERMUTE is an error; then reset lands mid-pulse.
      step(1, 0, 1, 0, 0, 0);
      absorb(0, 0);
      permute(0, 0, 12);
      step(1, 0, 1, 0, 0, 0);
      chk("permute_start_err", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      step(1, 0, 0, 0, 1, 0);
      chk("round12", mk(0, 0, 0, 1, 12, 0, 0, 1, 0, 1));
      #2;
      ovr_rst1 = 1'b1;
      #1;
      chk("midrun_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      step_en = 1'b0; cmd_round = 1'b0;
      ovr_rst1 = 1'b0;
      step(1, 0, 0, 0, 1, 0);
      chk("post_reset_idle_round", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      chk("post_reset_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      step(1, 0, 0, 1, 0, 0);
      chk("post_reset_load", mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      step(0, 0, 0, 0, 0, 0);
      chk("pulse_drop", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
